counter_seq_ctrl: RTL and testbench

//   Sequencer/controller for the DFF-based down-counter datapath in counter_IV.

---
 rtl/counter_seq_ctrl.sv | 87 ++++++++
 tb/tb_counter_seq_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: IDLE/RUN/DONE sequencer owning a prescaled down-count register
// with load, start/stop, one-shot or auto-reload terminal handling and a registered TC pulse.
module counter_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int PSC_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [WIDTH-1:0] reload_val_i,
  input  logic             mode_i,
  input  logic [PSC_W-1:0] psc_i,
  output logic [WIDTH-1:0] q_o,
  output logic             run_o,
  output logic             done_o,
  output logic             tc_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [PSC_W-1:0]   psc_q, psc_d;
  logic               tc_q, tc_d;
  logic               tick;
  assign tick = (psc_q == psc_i);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      q_q     <= '0;
      psc_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      psc_q   <= psc_d;
      tc_q    <= tc_d;
    end
  end
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    psc_d   = psc_q;
    tc_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_i) q_d = load_val_i;
        else if (start_i && !stop_i && q_q != '0) begin
          state_d = RUN;
          psc_d   = '0;
        end
      end
      RUN: begin
        if (stop_i) begin
          state_d = IDLE;
          psc_d   = '0;
        end else if (load_i) begin
          q_d     = load_val_i;
          psc_d   = '0;
          state_d = (load_val_i == '0) ? DONE : RUN;
        end else if (!tick) psc_d = psc_q + 1'b1;
        else begin
          psc_d = '0;
          if (q_q > WIDTH'(1)) q_d = q_q - 1'b1;
          else begin
            // Terminal count: reload only when a non-zero reload value exists.
            tc_d    = 1'b1;
            q_d     = (mode_i && reload_val_i != '0) ? reload_val_i : '0;
            state_d = (mode_i && reload_val_i != '0) ? RUN : DONE;
          end
        end
      end
      DONE: begin
        if (load_i) begin
          q_d     = load_val_i;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign q_o    = q_q;
  assign run_o  = (state_q == RUN);
  assign done_o = (state_q == DONE);
  assign tc_o   = tc_q;
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: directed vector table plus a hand sequence for prescaler wrap.
module tb_counter_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst, start, stop, load, mode;
  logic [7:0] load_val, reload_val, q;
  logic [3:0] psc;
  logic       run, done, tc;
  int         checks = 0;
  int         failures = 0;
  typedef struct {
    logic       rst, start, stop, load;
    logic [7:0] lv, rv;
    logic       mode;
    logic [3:0] psc;
    logic [7:0] eq;
    logic       erun, edone, etc;
  } vec_t;
  vec_t vq[$];
  counter_seq_ctrl #(.WIDTH(8), .PSC_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .load_i(load),
    .load_val_i(load_val), .reload_val_i(reload_val), .mode_i(mode), .psc_i(psc),
    .q_o(q), .run_o(run), .done_o(done), .tc_o(tc)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic r, logic st, logic sp, logic ld, logic [7:0] lv,
                              logic [7:0] rv, logic md, logic [3:0] p, logic [7:0] eq,
                              logic erun, logic edone, logic etc);
    vec_t v;
    v.rst = r; v.start = st; v.stop = sp; v.load = ld; v.lv = lv; v.rv = rv;
    v.mode = md; v.psc = p; v.eq = eq; v.erun = erun; v.edone = edone; v.etc = etc;
    return v;
  endfunction
  task automatic drive(logic r, logic st, logic sp, logic ld, logic [7:0] lv,
                       logic [7:0] rv, logic md, logic [3:0] p);
    @(negedge clk);
    rst = r; start = st; stop = sp; load = ld; load_val = lv; reload_val = rv;
    mode = md; psc = p;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n;
    rst = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0; mode = 1'b0;
    load_val = '0; reload_val = '0; psc = '0;
    vq.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk(0,0,0,1,3,0,0,0, 3,0,0,0));
    vq.push_back(mk(0,1,0,0,0,0,0,0, 3,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0, 2,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0, 1,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0, 0,0,1,1));
    vq.push_back(mk(0,0,0,0,0,0,0,0, 0,0,1,0));
    vq.push_back(mk(0,1,1,0,0,0,0,0, 0,0,1,0));
    vq.push_back(mk(0,0,0,1,2,0,0,0, 2,0,0,0));
    vq.push_back(mk(0,1,0,0,0,0,0,2, 2,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,2, 2,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,2, 2,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,2, 1,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,2, 1,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,2, 1,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,2, 0,0,1,1));
    vq.push_back(mk(0,0,0,1,1,0,0,0, 1,0,0,0));
    vq.push_back(mk(0,1,0,0,0,2,1,0, 1,1,0,0));
    vq.push_back(mk(0,0,0,0,0,2,1,0, 2,1,0,1));
    vq.push_back(mk(0,0,0,0,0,2,1,0, 1,1,0,0));
    vq.push_back(mk(0,0,0,0,0,2,1,0, 2,1,0,1));
    vq.push_back(mk(0,0,0,0,0,2,1,0, 1,1,0,0));
    vq.push_back(mk(0,0,0,1,5,2,1,0, 5,1,0,0));
    vq.push_back(mk(0,0,1,0,0,2,1,0, 5,0,0,0));
    vq.push_back(mk(0,1,0,0,0,0,0,1, 5,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,1, 5,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,1, 4,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,1, 4,1,0,0));
    vq.push_back(mk(0,0,0,1,8'h80,0,0,1, 8'h80,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,1, 8'h80,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,1, 8'h7f,1,0,0));
    vq.push_back(mk(0,0,0,1,0,0,0,1, 0,0,1,0));
    vq.push_back(mk(0,0,0,1,0,0,0,0, 0,0,0,0));
    vq.push_back(mk(0,1,0,1,4,0,0,0, 4,0,0,0));
    vq.push_back(mk(0,0,0,1,0,0,0,0, 0,0,0,0));
    vq.push_back(mk(0,1,0,0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk(0,0,0,1,7,0,0,0, 7,0,0,0));
    vq.push_back(mk(0,1,0,0,0,0,0,0, 7,1,0,0));
    vq.push_back(mk(1,0,0,0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk(0,0,0,1,1,0,0,0, 1,0,0,0));
    vq.push_back(mk(0,1,0,0,0,0,1,0, 1,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0,1,0, 0,0,1,1));
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].start, vq[i].stop, vq[i].load, vq[i].lv, vq[i].rv,
            vq[i].mode, vq[i].psc);
      checks++;
      if ({q, run, done, tc} !== {vq[i].eq, vq[i].erun, vq[i].edone, vq[i].etc}) begin
        failures++;
        $display("FAIL vec%0d: got q=%h run=%b done=%b tc=%b, want q=%h run=%b done=%b tc=%b",
                 i, q, run, done, tc, vq[i].eq, vq[i].erun, vq[i].edone, vq[i].etc);
      end
    end
    // Lower PSC below the running prescaler count: it must wrap through 16 first.
    drive(0,0,0,1,9,0,0,5);
    drive(0,1,0,0,0,0,0,5);
    drive(0,0,0,0,0,0,0,5);
    drive(0,0,0,0,0,0,0,5);
    drive(0,0,0,0,0,0,0,5);
    n = 0;
    while (q == 8'd9 && n < 40) begin
      drive(0,0,0,0,0,0,0,1);
      n++;
    end
    checks++;
    if (n != 15 || q != 8'd8) begin
      failures++;
      $display("FAIL psc_wrap: got edges=%0d q=%h, want edges=15 q=08", n, q);
    end
    checks++;
    if (!run || tc) begin
      failures++;
      $display("FAIL psc_wrap_state: got run=%b tc=%b, want run=1 tc=0", run, tc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
